mfp_7seg_scan_ctrl: RTL and testbench
=====================================

Name: mfp_7seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 8-digit common-anode 7-segment display on the SWORD/Nexys4-DDR boards. It takes the 32-bit 7SEG GPIO register value (8 hex nibbles, digit 0 = bits 3:0) plus per-digit enable and decimal-point masks. It cycles the digits with a blanking gap to suppress ghosting and drives the active-low anode and segment pins. It sits between the AHB GPIO slave outputs and the board top-level pins.

Parameters:
SCAN_DIV, 100000, HCLK cycles each digit is lit (>=1; 1 ms at 100 MHz)
BLANK_DIV, 1000, HCLK cycles all anodes are off between digits (0 = no blank phase)
N_DIGITS, 8, number of digits scanned (fixed 8 in this revision)

Ports:
HCLK  in  1  system clock
HRESET  in  1  asynchronous reset, active-high
IO_7SEG  in  32  hex value; nibble i drives digit i
DIGIT_EN  in  8  per-digit enable; 0 = digit dark for its slot
DP_IN  in  8  per-digit decimal point, 1 = lit
LZ_EN  in  1  leading-zero suppression enable
AN  out  8  anode selects, active-low, one-hot-low when lit
SEG  out  8  {DP,g,f,e,d,c,b,a}, active-low
FRAME_TICK  out  1  one-cycle pulse when digit 0 slot begins

Behaviour:
- Reset (asynchronous, immediate): AN=8'hFF, SEG=8'hFF, FRAME_TICK=0, digit index=0, state=BLANK, counter=0, shadow register=0.
- FSM states BLANK, SHOW.
  - BLANK: AN=8'hFF, SEG=8'hFF. Runs BLANK_DIV cycles (counter 0..BLANK_DIV-1), then goes to SHOW for the current index.
  - BLANK_DIV=0: BLANK lasts exactly 1 cycle after reset only; between digits, SHOW goes directly to SHOW of the next index.
  - SHOW: runs SCAN_DIV cycles. On the last cycle, index increments mod 8 (7 wraps to 0) and the FSM enters BLANK (or SHOW per above).
- Shadow: on the cycle entering SHOW with index 0, IO_7SEG, DIGIT_EN, DP_IN and LZ_EN are captured into shadow registers. The whole frame uses the shadow, so there is no tearing. Mid-frame input changes take effect at the next frame.
- FRAME_TICK: asserted for exactly the first cycle of each index-0 SHOW.
- Outputs are registered. AN and SEG for index i appear on the first SHOW cycle and are held constant for all SCAN_DIV cycles.
- Lit condition for digit i is all of:
  - shadow DIGIT_EN[i]=1;
  - NOT (LZ_EN and i>=1 and shadow nibbles i..7 all zero).
  - Digit 0 is never suppressed by LZ.
- When a digit is not lit: its slot still elapses with AN=8'hFF and SEG=8'hFF, so brightness stays uniform.
- When a digit is lit:
  - AN[i]=0, all other AN bits 1.
  - SEG[6:0]=hex decode of nibble i; SEG[7]=~DP[i].
- Decode (active-low {g..a}):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Counter width is $clog2(max(SCAN_DIV,BLANK_DIV)+1). No overflow is possible; the counter clears on every state change.
- Never more than one AN bit low in any cycle; AN=8'hFF during every BLANK cycle.
- Reset mid-SHOW: AN and SEG go to FF immediately. After release, scanning restarts at BLANK with index 0.

Decomposition:
- Shared header mfp_ahb_const.vh: MFP_N_7SEG (32), MFP_N_DIGITS (8), and the 16 segment-encoding constants (H7SEG_0..H7SEG_F).
- One natural combinational sub-module, mfp_hex7seg: 4-bit nibble -> 7-bit active-low segments. It is instantiated once on the muxed nibble, and its output is registered in the parent.
- FSM, counter, index and shadow registers stay in mfp_7seg_scan_ctrl.

Test Plan:
1. SCAN_DIV=4, BLANK_DIV=1, IO_7SEG=32'h76543210, DIGIT_EN=FF, DP_IN=00, LZ_EN=0.
   - AN sequence FE,FD,...,7F, each held 4 cycles with FF for 1 cycle between.
   - SEG for digit 0=C0, 1=F9, 7=F8.
   - FRAME_TICK every 40 cycles.
2. IO_7SEG=32'h00000A0F, LZ_EN=1.
   - Digits 0,1,2 lit with SEG 8E, C0, 88.
   - Digits 3..7: AN=FF during their slots.
   - Same value with LZ_EN=0: digit 3 shows C0.
3. DIGIT_EN=8'h05, DP_IN=8'h04, IO_7SEG=32'h88888888.
   - Only AN=FE (SEG=80) and AN=FB (SEG=00) ever appear.
   - Frame period unchanged at 40 cycles.
4. Change IO_7SEG from 32'h11111111 to 32'h22222222 while digit 3 is shown.
   - Digits 4..7 still show F9.
   - The next frame, starting with FRAME_TICK, shows A4 on all digits.
5. Assert HRESET mid-SHOW of digit 5 for 1 cycle (asynchronous, between clock edges).
   - AN=FF and SEG=FF immediately.
   - After release: one BLANK cycle, then AN=FE with FRAME_TICK=1.
6. BLANK_DIV=0, SCAN_DIV=1.
   - AN rotates every cycle FE,FD,...,7F,FE with no FF gaps after the first cycle.
   - AN is one-hot-low in every cycle.

Source files
------------

// File: rtl/mfp_7seg_scan_ctrl_pkg.sv
// mfp_7seg_scan_ctrl_pkg: shared widths, segment encodings and types for the 7-segment scan controller
package mfp_7seg_scan_ctrl_pkg;
    localparam int MFP_N_7SEG   = 32;
    localparam int MFP_N_DIGITS = 8;
    // Active-low {g,f,e,d,c,b,a} encodings for hex digits
    localparam logic [6:0] H7SEG_0 = 7'h40;
    localparam logic [6:0] H7SEG_1 = 7'h79;
    localparam logic [6:0] H7SEG_2 = 7'h24;
    localparam logic [6:0] H7SEG_3 = 7'h30;
    localparam logic [6:0] H7SEG_4 = 7'h19;
    localparam logic [6:0] H7SEG_5 = 7'h12;
    localparam logic [6:0] H7SEG_6 = 7'h02;
    localparam logic [6:0] H7SEG_7 = 7'h78;
    localparam logic [6:0] H7SEG_8 = 7'h00;
    localparam logic [6:0] H7SEG_9 = 7'h10;
    localparam logic [6:0] H7SEG_A = 7'h08;
    localparam logic [6:0] H7SEG_B = 7'h03;
    localparam logic [6:0] H7SEG_C = 7'h46;
    localparam logic [6:0] H7SEG_D = 7'h21;
    localparam logic [6:0] H7SEG_E = 7'h06;
    localparam logic [6:0] H7SEG_F = 7'h0E;
    typedef enum logic {BLANK, SHOW} state_t;
    // Per-frame snapshot of the display inputs
    typedef struct packed {
        logic [MFP_N_7SEG-1:0]   val;
        logic [MFP_N_DIGITS-1:0] en;
        logic [MFP_N_DIGITS-1:0] dp;
        logic                    lz;
    } shadow_t;
endpackage

// File: rtl/mfp_hex7seg.sv
// mfp_hex7seg: 4-bit nibble to active-low 7-segment pattern
//   nibble in  4  hex value
//   seg    out 7  {g,f,e,d,c,b,a}, active-low
module mfp_hex7seg
    import mfp_7seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    always_comb begin
        case (nibble)
            4'h0: seg = H7SEG_0;
            4'h1: seg = H7SEG_1;
            4'h2: seg = H7SEG_2;
            4'h3: seg = H7SEG_3;
            4'h4: seg = H7SEG_4;
            4'h5: seg = H7SEG_5;
            4'h6: seg = H7SEG_6;
            4'h7: seg = H7SEG_7;
            4'h8: seg = H7SEG_8;
            4'h9: seg = H7SEG_9;
            4'hA: seg = H7SEG_A;
            4'hB: seg = H7SEG_B;
            4'hC: seg = H7SEG_C;
            4'hD: seg = H7SEG_D;
            4'hE: seg = H7SEG_E;
            default: seg = H7SEG_F;
        endcase
    end
endmodule

// File: rtl/mfp_7seg_scan_ctrl.sv
// mfp_7seg_scan_ctrl: blanked time-multiplexed scan of an 8-digit common-anode 7-segment display
//   HCLK       in  1   system clock
//   HRESET     in  1   asynchronous reset, active-high
//   IO_7SEG    in  32  hex value, nibble i drives digit i
//   DIGIT_EN   in  8   per-digit enable
//   DP_IN      in  8   per-digit decimal point, 1 = lit
//   LZ_EN      in  1   leading-zero suppression enable
//   AN         out 8   anode selects, active-low
//   SEG        out 8   {DP,g,f,e,d,c,b,a}, active-low
//   FRAME_TICK out 1   pulse on the first cycle of digit 0
module mfp_7seg_scan_ctrl
    import mfp_7seg_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_DIV = 1000,
    parameter int N_DIGITS  = MFP_N_DIGITS
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic [MFP_N_7SEG-1:0]   IO_7SEG,
    input  logic [MFP_N_DIGITS-1:0] DIGIT_EN,
    input  logic [MFP_N_DIGITS-1:0] DP_IN,
    input  logic                    LZ_EN,
    output logic [7:0]              AN,
    output logic [7:0]              SEG,
    output logic                    FRAME_TICK
);
    localparam int CMAX = (SCAN_DIV > BLANK_DIV) ? SCAN_DIV : BLANK_DIV;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
    // With no blank phase the post-reset BLANK still lasts one cycle
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_DIV == 0) ? 0 : BLANK_DIV - 1);
    localparam logic [2:0]    IDX_LAST   = 3'(N_DIGITS - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    shadow_t           sh_q, sh_d;
    logic [7:0]        an_q, an_d, seg_q, seg_d;
    logic              tick_q, tick_d;
    logic [31:0]       val_sh;
    logic [6:0]        hex;
    logic              lit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        if (state_q == BLANK && cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
        end else if (state_q == SHOW && cnt_q == SCAN_LAST) begin
            state_d = (BLANK_DIV == 0) ? SHOW : BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 1'b1;
        end
        // A fresh SHOW slot is the only time the counter is zero in SHOW
        tick_d = state_d == SHOW && cnt_d == '0 && idx_d == 3'd0;
        // Outputs are computed from next-state values so they register with the slot start
        sh_d   = tick_d ? {IO_7SEG, DIGIT_EN, DP_IN, LZ_EN} : sh_q;
        val_sh = sh_d.val >> {idx_d, 2'b00};
    end

    mfp_hex7seg u_hex (
        .nibble (val_sh[3:0]),
        .seg    (hex)
    );

    always_comb begin
        // val_sh == 0 means this digit and every higher nibble are zero
        lit   = state_d == SHOW && sh_d.en[idx_d] && !(sh_d.lz && idx_d != 3'd0 && val_sh == '0);
        an_d  = lit ? ~(8'd1 << idx_d) : 8'hFF;
        seg_d = lit ? {~sh_d.dp[idx_d], hex} : 8'hFF;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            an_q    <= 8'hFF;
            seg_q   <= 8'hFF;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            tick_q  <= tick_d;
        end
    end

    assign AN         = an_q;
    assign SEG        = seg_q;
    assign FRAME_TICK = tick_q;
endmodule

// File: tb/tb_mfp_7seg_scan_ctrl.sv
// tb_mfp_7seg_scan_ctrl: randomized and directed checks of the scan controller against a timeline model
module tb_mfp_7seg_scan_ctrl;
    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [31:0] IO_7SEG = 32'h76543210;
    logic [7:0]  DIGIT_EN = 8'hFF;
    logic [7:0]  DP_IN = 8'h00;
    logic        LZ_EN = 1'b0;
    logic [7:0]  AN, SEG, AN2, SEG2;
    logic        FRAME_TICK, FT2;
    int          checks = 0;
    int          errors = 0;

    // Reference: digit slot = 4 lit + 1 blank cycles, frame = 40 cycles, counted in edges since reset release
    int          n;
    logic [31:0] m_val;
    logic [7:0]  m_en, m_dp;
    logic        m_lz;
    logic [6:0]  hex [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    mfp_7seg_scan_ctrl #(.SCAN_DIV(4), .BLANK_DIV(1)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .IO_7SEG(IO_7SEG), .DIGIT_EN(DIGIT_EN),
        .DP_IN(DP_IN), .LZ_EN(LZ_EN), .AN(AN), .SEG(SEG), .FRAME_TICK(FRAME_TICK)
    );

    mfp_7seg_scan_ctrl #(.SCAN_DIV(1), .BLANK_DIV(0)) dut2 (
        .HCLK(HCLK), .HRESET(HRESET), .IO_7SEG(IO_7SEG), .DIGIT_EN(DIGIT_EN),
        .DP_IN(DP_IN), .LZ_EN(LZ_EN), .AN(AN2), .SEG(SEG2), .FRAME_TICK(FT2)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            n <= 0;
            m_val <= '0;
            m_en <= '0;
            m_dp <= '0;
            m_lz <= 1'b0;
        end else begin
            if (n % 40 == 0) begin
                m_val <= IO_7SEG;
                m_en <= DIGIT_EN;
                m_dp <= DP_IN;
                m_lz <= LZ_EN;
            end
            n <= n + 1;
        end
    end

    function automatic logic [16:0] exp_out(input int cyc);
        int p, d;
        logic [16:0] r;
        if (cyc == 0) return {1'b0, 16'hFFFF};
        p = (cyc - 1) % 40;
        d = p / 5;
        r = {p == 0, 16'hFFFF};
        if (p % 5 != 4 && m_en[d] && !(m_lz && d > 0 && (m_val >> (4 * d)) == 0))
            r[15:0] = {~(8'h01 << d), ~m_dp[d], hex[m_val[4*d +: 4]]};
        return r;
    endfunction

    task automatic wait_tick();
        @(negedge HCLK);
        for (int t = 0; t < 100 && !FRAME_TICK; t++) @(negedge HCLK);
        checks++;
        if (!FRAME_TICK) begin
            errors++;
            $display("FAIL tick_timeout FRAME_TICK=%b expected 1 within 100 cycles", FRAME_TICK);
        end
    endtask

    task automatic test_reset();
        @(negedge HCLK);
        #2 HRESET = 1'b1;
        #1;
        checks++;
        if ({FRAME_TICK, AN, SEG} !== {1'b0, 16'hFFFF}) begin
            errors++;
            $display("FAIL reset_state got %b/%h/%h expected 0/ff/ff", FRAME_TICK, AN, SEG);
        end
        @(negedge HCLK);
        HRESET = 1'b0;
        checks++;
        if ({FRAME_TICK, AN, SEG} !== exp_out(n)) begin
            errors++;
            $display("FAIL reset_release got %h expected %h", {FRAME_TICK, AN, SEG}, exp_out(n));
        end
    endtask

    task automatic test_scan();
        int last = -1;
        for (int k = 0; k < 90; k++) begin
            @(negedge HCLK);
            checks++;
            if ({FRAME_TICK, AN, SEG} !== exp_out(n)) begin
                errors++;
                $display("FAIL scan_model n=%0d got %h expected %h", n, {FRAME_TICK, AN, SEG}, exp_out(n));
            end
            if (n == 1 || n == 6 || n == 36) begin
                checks++;
                if ({AN, SEG} !== (n == 1 ? 16'hFEC0 : n == 6 ? 16'hFDF9 : 16'h7FF8)) begin
                    errors++;
                    $display("FAIL scan_digit n=%0d got %h/%h", n, AN, SEG);
                end
            end
            if (FRAME_TICK) begin
                if (last >= 0) begin
                    checks++;
                    if (n - last !== 40) begin
                        errors++;
                        $display("FAIL frame_period got %0d expected 40", n - last);
                    end
                end
                last = n;
            end
        end
    endtask

    task automatic test_lz();
        logic [15:0] want;
        for (int pass = 0; pass < 2; pass++) begin
            IO_7SEG = 32'h00000A0F;
            LZ_EN = (pass == 0);
            wait_tick();
            for (int k = 0; k < 40; k++) begin
                if (k > 0) @(negedge HCLK);
                checks++;
                if ({FRAME_TICK, AN, SEG} !== exp_out(n)) begin
                    errors++;
                    $display("FAIL lz_model n=%0d got %h expected %h", n, {FRAME_TICK, AN, SEG}, exp_out(n));
                end
                if (k == 0 || k == 5 || k == 10 || k == 15 || k == 35) begin
                    want = k == 0 ? 16'hFE8E : k == 5 ? 16'hFDC0 : k == 10 ? 16'hFB88 :
                           k == 15 ? (pass == 0 ? 16'hFFFF : 16'hF7C0) : (pass == 0 ? 16'hFFFF : 16'h7FC0);
                    checks++;
                    if ({AN, SEG} !== want) begin
                        errors++;
                        $display("FAIL lz_digit lz=%0d k=%0d got %h expected %h", LZ_EN, k, {AN, SEG}, want);
                    end
                end
            end
        end
    endtask

    task automatic test_dp_en();
        IO_7SEG = 32'h88888888;
        DIGIT_EN = 8'h05;
        DP_IN = 8'h04;
        LZ_EN = 1'b0;
        wait_tick();
        for (int k = 0; k < 81; k++) begin
            if (k > 0) @(negedge HCLK);
            checks++;
            if ({FRAME_TICK, AN, SEG} !== exp_out(n)) begin
                errors++;
                $display("FAIL dp_model n=%0d got %h expected %h", n, {FRAME_TICK, AN, SEG}, exp_out(n));
            end
            checks++;
            if (!({AN, SEG} == 16'hFE80 || {AN, SEG} == 16'hFB00 || {AN, SEG} == 16'hFFFF)) begin
                errors++;
                $display("FAIL dp_pattern k=%0d got %h/%h", k, AN, SEG);
            end
            checks++;
            if (FRAME_TICK !== (k % 40 == 0)) begin
                errors++;
                $display("FAIL dp_tick k=%0d got %b", k, FRAME_TICK);
            end
        end
    endtask

    task automatic test_tearing();
        IO_7SEG = 32'h11111111;
        DIGIT_EN = 8'hFF;
        DP_IN = 8'h00;
        wait_tick();
        for (int k = 0; k < 80; k++) begin
            if (k > 0) @(negedge HCLK);
            checks++;
            if ({FRAME_TICK, AN, SEG} !== exp_out(n)) begin
                errors++;
                $display("FAIL tear_model n=%0d got %h expected %h", n, {FRAME_TICK, AN, SEG}, exp_out(n));
            end
            if (k % 5 != 4 && (k >= 40 || k >= 20)) begin
                checks++;
                if (SEG !== (k < 40 ? 8'hF9 : 8'hA4)) begin
                    errors++;
                    $display("FAIL tear_seg k=%0d got %h expected %h", k, SEG, k < 40 ? 8'hF9 : 8'hA4);
                end
            end
            if (k == 40) begin
                checks++;
                if (FRAME_TICK !== 1'b1) begin
                    errors++;
                    $display("FAIL tear_tick got %b expected 1", FRAME_TICK);
                end
            end
            if (k == 15) IO_7SEG = 32'h22222222;
        end
    endtask

    task automatic test_reset_mid_show();
        wait_tick();
        for (int k = 0; k < 26; k++) @(negedge HCLK);
        checks++;
        if (AN !== 8'hDF) begin
            errors++;
            $display("FAIL rst_pre got AN=%h expected df", AN);
        end
        #2 HRESET = 1'b1;
        #1;
        checks++;
        if ({FRAME_TICK, AN, SEG} !== {1'b0, 16'hFFFF}) begin
            errors++;
            $display("FAIL rst_async got %b/%h/%h expected 0/ff/ff", FRAME_TICK, AN, SEG);
        end
        @(negedge HCLK);
        HRESET = 1'b0;
        checks++;
        if ({FRAME_TICK, AN, SEG} !== {1'b0, 16'hFFFF}) begin
            errors++;
            $display("FAIL rst_blank got %b/%h/%h expected 0/ff/ff", FRAME_TICK, AN, SEG);
        end
        @(negedge HCLK);
        checks++;
        if ({FRAME_TICK, AN, SEG} !== {1'b1, 16'hFEA4}) begin
            errors++;
            $display("FAIL rst_restart got %b/%h/%h expected 1/fe/a4", FRAME_TICK, AN, SEG);
        end
    endtask

    task automatic test_no_blank();
        int d;
        IO_7SEG = $urandom;
        DP_IN = 8'($urandom);
        DIGIT_EN = 8'hFF;
        LZ_EN = 1'b0;
        @(negedge HCLK);
        #2 HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
        checks++;
        if ({FT2, AN2, SEG2} !== {1'b0, 16'hFFFF}) begin
            errors++;
            $display("FAIL nb_reset got %b/%h/%h expected 0/ff/ff", FT2, AN2, SEG2);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge HCLK);
            d = (n - 1) % 8;
            checks++;
            if ({FT2, AN2, SEG2} !== {d == 0, ~(8'h01 << d), ~DP_IN[d], hex[IO_7SEG[4*d +: 4]]}) begin
                errors++;
                $display("FAIL nb_rotate n=%0d got %b/%h/%h expected digit %0d", n, FT2, AN2, SEG2, d);
            end
            checks++;
            if ($countones(~AN2) !== 1) begin
                errors++;
                $display("FAIL nb_onehot got AN=%h expected one low bit", AN2);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            @(negedge HCLK);
            checks++;
            if ({FRAME_TICK, AN, SEG} !== exp_out(n)) begin
                errors++;
                $display("FAIL rand_model n=%0d got %h expected %h", n, {FRAME_TICK, AN, SEG}, exp_out(n));
            end
            checks++;
            if ($countones(~AN) > 1) begin
                errors++;
                $display("FAIL rand_onehot got AN=%h expected at most one low bit", AN);
            end
            if ($urandom_range(0, 14) == 0) begin
                IO_7SEG = $urandom >> $urandom_range(0, 31);
                DIGIT_EN = 8'($urandom);
                DP_IN = 8'($urandom);
                LZ_EN = 1'($urandom);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_scan();
        test_lz();
        test_dp_en();
        test_tearing();
        test_reset_mid_show();
        test_no_blank();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
